mult_console_ctrl: RTL and testbench
====================================

# mult_console_ctrl

Parametrised control block for the sequential signed multiplier on the FPGA board. It conditions the raw START and CLEAR buttons and captures operands on a validated press. It launches the N-bit multiplier with a single-cycle start pulse, waits for completion with a timeout, and holds the product. It also keeps a saturating multiply-accumulate register and selects one of four display sources for the downstream signed-decimal display converter.

## Interface
Parameters:
- N, 8, operand width; product and accumulator width is 2N
- DEB_CYCLES, 250000, cycles a button level must stay stable to be accepted (5 ms at 50 MHz)
- TIMEOUT_CYCLES, 4N+8, maximum cycles from MULT_START to END_MULT

Ports:
- CLOCK, in, 1, board clock; single clock domain
- RESET, in, 1, asynchronous, active-low reset
- BTN_START, in, 1, raw start button, active-low, asynchronous to CLOCK
- BTN_CLR, in, 1, raw accumulator-clear button, active-low, asynchronous
- MODE, in, 2, display select: 00 live A/B, 01 last product, 10 accumulator, 11 captured operands
- SW_A / SW_B, in, N each, signed operand switches
- S, in, 2N, signed product from the multiplier
- END_MULT, in, 1, multiplier completion flag
- MULT_START, out, 1, one-cycle launch pulse to the multiplier
- A_OP / B_OP, out, N each, captured operands; stable from launch to completion
- DISP_VALUE, out, 2N, signed value to display
- DISP_SPLIT, out, 1, 1 = DISP_VALUE carries two N-bit signed fields {hi, lo}
- BUSY, out, 1, operation in flight
- RESULT_VALID, out, 1, product register holds a completed result
- SAT, out, 1, sticky accumulator-saturation flag
- ERR_TIMEOUT, out, 1, sticky timeout flag

## Operation
- Button conditioning:
  - 2-flop synchroniser, then a debounce counter; the accepted level changes only after DEB_CYCLES consecutive equal samples.
  - A press is the accepted-level falling edge and produces a one-cycle internal pulse.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
  - IDLE: a start press captures SW_A/SW_B into A_OP/B_OP, clears the timeout counter, then goes to LAUNCH.
  - LAUNCH: MULT_START=1 for exactly this cycle, BUSY=1, then goes to WAIT.
  - WAIT: BUSY=1 and the counter increments.
    - END_MULT=1: latch S into the product register, add it to the accumulator, set RESULT_VALID, go to DONE.
    - Counter reaches TIMEOUT_CYCLES: set ERR_TIMEOUT, leave product and accumulator unchanged, go to IDLE.
  - DONE: one cycle, BUSY=0, then IDLE.
- Start presses outside IDLE are dropped, not queued.
- Accumulator: signed 2N bits, computed with a 2N+1-bit sum.
  - Above 2^(2N-1)-1 clamps to the maximum; below -2^(2N-1) clamps to the minimum. Either case sets SAT.
  - A clear press zeroes the accumulator and SAT (ERR_TIMEOUT is unaffected). If a clear and an accumulate land in the same cycle, the clear wins.
- Display mux (combinational from registers and switches):
  - 00: {SW_A, SW_B}, DISP_SPLIT=1
  - 01: product, DISP_SPLIT=0; shows 0 until RESULT_VALID
  - 10: accumulator, DISP_SPLIT=0
  - 11: {A_OP, B_OP}, DISP_SPLIT=1
- A new start press clears ERR_TIMEOUT.

## Timing
- Reset values: all outputs 0; FSM in IDLE; debounced levels = released (1).
- Press to MULT_START: 2 synchroniser cycles + DEB_CYCLES + 1 edge cycle + 1 capture cycle.
- END_MULT sampled in WAIT at cycle k: product, accumulator, RESULT_VALID and SAT are updated at edge k+1; BUSY falls at edge k+1.
- END_MULT high in the LAUNCH cycle is ignored, so a stale flag from the previous operation cannot complete a new one.
- Reset asserted mid-operation: immediate abort. No MULT_START is produced after deassertion until a new press is accepted.

## Structure
- Package mult_pkg holds:
  - typedef enum for the FSM state
  - typedef enum for the MODE encodings
  - localparam helper for the saturation bounds of a 2N-bit signed value
- One sub-module, btn_conditioner (synchroniser, debounce, falling-edge pulse), instanced twice: START and CLR.
- This block instances neither the multiplier nor the display decoders; the board top wires them.

## Test plan
Bench uses N=8, DEB_CYCLES=4 and a behavioural multiplier model with 10-cycle latency.
- A=-7, B=12, clean press: exactly one MULT_START; after END_MULT, product=-84, RESULT_VALID=1, accumulator=-84, BUSY high for 11 cycles.
- Bouncy press (3-cycle glitches, then stable low): exactly one MULT_START. A second press while BUSY produces no extra launch.
- Three runs of 127*127: accumulator = 16129, then 32258, then 32767 with SAT=1. A clear press then gives accumulator=0 and SAT=0.
- Model never asserts END_MULT: ERR_TIMEOUT=1 after TIMEOUT_CYCLES=40; product and RESULT_VALID unchanged; the next press clears the flag.
- Mode sweep with A=-128, B=-128 captured: mode 01 shows 16384. Mode 11 shows {0x80,0x80} with DISP_SPLIT=1 while SW_A/SW_B are changed.
- RESET low during WAIT: all outputs 0 asynchronously. A late END_MULT after release leaves the product at 0.

Source files
------------

// File: rtl/mult_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared types and helpers for the multiplier console
//                controller: FSM state encoding, display-mode encoding and
//                saturation bounds for a W-bit two's-complement value.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Controller FSM states (explicit 2-bit encoding).
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Display source selected by the MODE switches.
    typedef enum logic [1:0] {
        MODE_LIVE = 2'b00,   // live switch operands {SW_A, SW_B}
        MODE_PROD = 2'b01,   // last completed product
        MODE_ACC  = 2'b10,   // multiply-accumulate register
        MODE_OPS  = 2'b11    // operands captured at launch
    } mode_e;

    // Widest value the bound helpers can describe.
    localparam int unsigned C_MAX_SAT_WIDTH = 64;

    // Largest positive W-bit signed value, returned in 64 bits.
    function automatic logic [C_MAX_SAT_WIDTH-1:0] sat_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative W-bit signed value, sign-extended to 64 bits.
    function automatic logic [C_MAX_SAT_WIDTH-1:0] sat_min(input int unsigned w);
        return ~sat_max(w);
    endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/btn_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : btn_conditioner
//  Description : Conditions one raw active-low push button: two-flop
//                synchroniser, debounce filter and a one-cycle pulse on the
//                accepted falling edge (the press).
//  Ports       : clk      - system clock
//                rst_n    - asynchronous active-low reset
//                i_btn_n  - raw button level, active-low, asynchronous
//                o_press  - one-cycle pulse when a press is accepted
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int              CW         = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]   c_cnt_last = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_q;
    logic [CW-1:0] r_cnt;

    // Synchroniser; resets to the released level so no press is invented
    // when reset is removed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: r_cnt counts consecutive samples that disagree with the
    // accepted level; any agreeing sample restarts the count, so the level
    // only moves after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else if (r_sync2 == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_q <= 1'b1;
        end else begin
            r_level_q <= r_level;
        end
    end

    // Falling edge of the accepted level, high for the single cycle after
    // the level changed.
    assign o_press = r_level_q & ~r_level;

endmodule : btn_conditioner
`default_nettype wire

// File: rtl/mult_console_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mult_console_ctrl
//  Description : Board-level controller for an N-bit sequential signed
//                multiplier. Captures operands on a debounced START press,
//                launches the multiplier with a one-cycle pulse, waits for
//                END_MULT with a timeout, holds the product, keeps a
//                saturating accumulator and muxes a display source.
//  Ports       : CLOCK, RESET        - clock, asynchronous active-low reset
//                BTN_START, BTN_CLR  - raw active-low buttons
//                MODE                - display source select
//                SW_A, SW_B          - signed operand switches
//                S, END_MULT         - multiplier product and done flag
//                MULT_START          - launch pulse to the multiplier
//                A_OP, B_OP          - operands held for the multiplier
//                DISP_VALUE/SPLIT    - value for the decimal display
//                BUSY, RESULT_VALID  - status
//                SAT, ERR_TIMEOUT    - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_console_ctrl
    import mult_pkg::*;
#(
    parameter int N              = 8,
    parameter int DEB_CYCLES     = 250000,
    parameter int TIMEOUT_CYCLES = 4 * N + 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             BTN_START,
    input  logic             BTN_CLR,
    input  logic [1:0]       MODE,
    input  logic [N-1:0]     SW_A,
    input  logic [N-1:0]     SW_B,
    input  logic [2*N-1:0]   S,
    input  logic             END_MULT,
    output logic             MULT_START,
    output logic [N-1:0]     A_OP,
    output logic [N-1:0]     B_OP,
    output logic [2*N-1:0]   DISP_VALUE,
    output logic             DISP_SPLIT,
    output logic             BUSY,
    output logic             RESULT_VALID,
    output logic             SAT,
    output logic             ERR_TIMEOUT
);

    localparam int                 W          = 2 * N;
    localparam int                 TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]      c_tmo_last = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [W-1:0]       c_acc_max  = W'(sat_max(W));
    localparam logic [W-1:0]       c_acc_min  = W'(sat_min(W));

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic w_start_press;
    logic w_clr_press;

    btn_conditioner #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_start (
        .clk     (CLOCK),
        .rst_n   (RESET),
        .i_btn_n (BTN_START),
        .o_press (w_start_press)
    );

    btn_conditioner #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_clr (
        .clk     (CLOCK),
        .rst_n   (RESET),
        .i_btn_n (BTN_CLR),
        .o_press (w_clr_press)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    state_e        r_state;
    state_e        w_state_next;
    logic [TW-1:0] r_tcnt;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. END_MULT is only looked at in WAIT, so a flag
    // still high from the previous operation during LAUNCH is ignored.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_press) begin
                    w_state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (END_MULT) begin
                    w_state_next = ST_DONE;
                end else if (r_tcnt == c_tmo_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath strobes
    // ------------------------------------------------------------------
    logic w_launch;
    logic w_busy;
    logic w_capture;
    logic w_complete;
    logic w_timeout;

    always_comb begin
        w_launch   = 1'b0;
        w_busy     = 1'b0;
        w_capture  = 1'b0;
        w_complete = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_capture = w_start_press;
            end
            ST_LAUNCH: begin
                w_launch = 1'b1;
                w_busy   = 1'b1;
            end
            ST_WAIT: begin
                w_busy     = 1'b1;
                w_complete = END_MULT;
                w_timeout  = ~END_MULT & (r_tcnt == c_tmo_last);
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator arithmetic: one guard bit; overflow shows as the two
    // top bits of the sum disagreeing.
    // ------------------------------------------------------------------
    logic [W-1:0] r_acc;
    logic [W:0]   w_sum;
    logic         w_pos_ovf;
    logic         w_neg_ovf;
    logic [W-1:0] w_acc_next;

    assign w_sum     = {r_acc[W-1], r_acc} + {S[W-1], S};
    assign w_pos_ovf = ~w_sum[W] &  w_sum[W-1];
    assign w_neg_ovf =  w_sum[W] & ~w_sum[W-1];

    always_comb begin
        if (w_pos_ovf) begin
            w_acc_next = c_acc_max;
        end else if (w_neg_ovf) begin
            w_acc_next = c_acc_min;
        end else begin
            w_acc_next = w_sum[W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [N-1:0] r_a_op;
    logic [N-1:0] r_b_op;
    logic [W-1:0] r_product;
    logic         r_result_valid;
    logic         r_sat;
    logic         r_err_timeout;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_a_op        <= '0;
            r_b_op        <= '0;
            r_tcnt        <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_capture) begin
                r_a_op        <= SW_A;
                r_b_op        <= SW_B;
                r_tcnt        <= '0;
                r_err_timeout <= 1'b0;
            end else if (r_state == ST_WAIT) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_product      <= '0;
            r_result_valid <= 1'b0;
        end else if (w_complete) begin
            r_product      <= S;
            r_result_valid <= 1'b1;
        end
    end

    // A clear press takes priority over an accumulate in the same cycle.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (w_clr_press) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (w_complete) begin
            r_acc <= w_acc_next;
            if (w_pos_ovf || w_neg_ovf) begin
                r_sat <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display mux
    // ------------------------------------------------------------------
    always_comb begin
        DISP_VALUE = '0;
        DISP_SPLIT = 1'b0;
        case (mode_e'(MODE))
            MODE_LIVE: begin
                DISP_VALUE = {SW_A, SW_B};
                DISP_SPLIT = 1'b1;
            end
            MODE_PROD: begin
                DISP_VALUE = r_result_valid ? r_product : '0;
            end
            MODE_ACC: begin
                DISP_VALUE = r_acc;
            end
            MODE_OPS: begin
                DISP_VALUE = {r_a_op, r_b_op};
                DISP_SPLIT = 1'b1;
            end
            default: begin
                DISP_VALUE = '0;
            end
        endcase
    end

    assign MULT_START   = w_launch;
    assign BUSY         = w_busy;
    assign A_OP         = r_a_op;
    assign B_OP         = r_b_op;
    assign RESULT_VALID = r_result_valid;
    assign SAT          = r_sat;
    assign ERR_TIMEOUT  = r_err_timeout;

endmodule : mult_console_ctrl
`default_nettype wire

// File: tb/tb_mult_console_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mult_console_ctrl
//  Description : Self-checking bench for mult_console_ctrl with a
//                behavioural multiplier model and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_console_ctrl;

    localparam int N   = 8;
    localparam int DEB = 4;
    localparam int TMO = 4 * N + 8;

    logic             CLOCK     = 1'b0;
    logic             RESET     = 1'b0;
    logic             BTN_START = 1'b1;
    logic             BTN_CLR   = 1'b1;
    logic [1:0]       MODE      = 2'b01;
    logic [N-1:0]     SW_A      = '0;
    logic [N-1:0]     SW_B      = '0;
    logic [2*N-1:0]   S         = '0;
    logic             END_MULT  = 1'b0;
    logic             MULT_START;
    logic [N-1:0]     A_OP;
    logic [N-1:0]     B_OP;
    logic [2*N-1:0]   DISP_VALUE;
    logic             DISP_SPLIT;
    logic             BUSY;
    logic             RESULT_VALID;
    logic             SAT;
    logic             ERR_TIMEOUT;

    mult_console_ctrl #(
        .N              (N),
        .DEB_CYCLES     (DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .BTN_START    (BTN_START),
        .BTN_CLR      (BTN_CLR),
        .MODE         (MODE),
        .SW_A         (SW_A),
        .SW_B         (SW_B),
        .S            (S),
        .END_MULT     (END_MULT),
        .MULT_START   (MULT_START),
        .A_OP         (A_OP),
        .B_OP         (B_OP),
        .DISP_VALUE   (DISP_VALUE),
        .DISP_SPLIT   (DISP_SPLIT),
        .BUSY         (BUSY),
        .RESULT_VALID (RESULT_VALID),
        .SAT          (SAT),
        .ERR_TIMEOUT  (ERR_TIMEOUT)
    );

    always #5 CLOCK = ~CLOCK;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0] prod;
        logic [15:0] acc;
        logic [15:0] ops;
        logic        rv;
        logic        sat;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          model_acc  = 0;
    bit          model_sat  = 1'b0;
    logic [15:0] model_prod = '0;
    bit          model_rv   = 1'b0;

    // Sets the switches and pushes the result the DUT must show when the
    // operation ends (completion, or timeout when tmo is set).
    task automatic expect_op(input logic signed [7:0] a, input logic signed [7:0] b, input bit tmo);
        exp_t e;
        int   p;
        int   sum;
        SW_A = a;
        SW_B = b;
        p    = int'(a) * int'(b);
        if (!tmo) begin
            sum = model_acc + p;
            if (sum > 32767) begin
                sum       = 32767;
                model_sat = 1'b1;
            end else if (sum < -32768) begin
                sum       = -32768;
                model_sat = 1'b1;
            end
            model_acc  = sum;
            model_prod = 16'(p);
            model_rv   = 1'b1;
        end
        e.prod = model_prod;
        e.acc  = 16'(model_acc);
        e.ops  = {a, b};
        e.rv   = model_rv;
        e.sat  = model_sat;
        e.err  = tmo;
        sb_q.push_back(e);
    endtask

    // ---------------- multiplier model ----------------
    int          lat_cycles = 10;
    bit          no_end     = 1'b0;
    int          lat        = 0;
    int          end_count  = 0;
    logic signed [7:0] pend_a = '0;
    logic signed [7:0] pend_b = '0;

    always @(negedge CLOCK) begin
        if (END_MULT) END_MULT = 1'b0;
        if (MULT_START) begin
            lat    = lat_cycles;
            pend_a = A_OP;
            pend_b = B_OP;
        end else if (lat > 0) begin
            lat--;
            if (lat == 0 && !no_end) begin
                S        = pend_a * pend_b;
                END_MULT = 1'b1;
                end_count++;
            end
        end
    end

    // ---------------- monitor ----------------
    int   launches      = 0;
    int   busy_cnt      = 0;
    int   last_busy_len = 0;
    bit   prev_busy     = 1'b0;
    exp_t mon_e;
    logic [1:0] saved_mode;

    always @(negedge CLOCK) begin
        if (!RESET) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (MULT_START) launches++;
            if (BUSY) busy_cnt++;
            if (prev_busy && !BUSY) begin
                last_busy_len = busy_cnt;
                busy_cnt      = 0;
                if (sb_q.size() == 0) begin
                    check_val("unexpected_end", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_val("result_valid", RESULT_VALID, mon_e.rv);
                    check_val("sat", SAT, mon_e.sat);
                    check_val("err_timeout", ERR_TIMEOUT, mon_e.err);
                    saved_mode = MODE;
                    MODE = 2'b01; #1;
                    check_val("product", DISP_VALUE, mon_e.prod);
                    MODE = 2'b10; #1;
                    check_val("accumulator", DISP_VALUE, mon_e.acc);
                    MODE = 2'b11; #1;
                    check_val("operands", DISP_VALUE, mon_e.ops);
                    MODE = saved_mode;
                end
            end
            prev_busy = BUSY;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic press_start();
        BTN_START = 1'b0; cycles(10);
        BTN_START = 1'b1; cycles(10);
    endtask

    task automatic press_bouncy();
        repeat (2) begin
            BTN_START = 1'b0; cycles(3);
            BTN_START = 1'b1; cycles(2);
        end
        BTN_START = 1'b0; cycles(12);
        BTN_START = 1'b1; cycles(10);
    endtask

    task automatic press_clr();
        BTN_CLR = 1'b0; cycles(10);
        BTN_CLR = 1'b1; cycles(10);
        model_acc = 0;
        model_sat = 1'b0;
    endtask

    task automatic wait_sb_empty();
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) cycles(1);
        if (sb_q.size() != 0) begin
            check_val("op_complete_bound", sb_q.size(), 0);
            sb_q.delete();
        end
        cycles(2);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit seen;
        int ends_before;

        // Reset state (MODE=01 so the display is also required to be 0).
        #2;
        check_val("rst_mult_start", MULT_START, 0);
        check_val("rst_busy", BUSY, 0);
        check_val("rst_ops", {A_OP, B_OP}, 0);
        check_val("rst_disp", {DISP_SPLIT, DISP_VALUE}, 0);
        check_val("rst_flags", {RESULT_VALID, SAT, ERR_TIMEOUT}, 0);
        cycles(2);
        RESET = 1'b1;
        cycles(5);

        // Clean press: -7 * 12.
        launches = 0;
        expect_op(-8'sd7, 8'sd12, 1'b0);
        press_start();
        wait_sb_empty();
        check_val("clean_launches", launches, 1);
        check_val("clean_busy_len", last_busy_len, 11);
        MODE = 2'b10; #1;
        check_val("clean_acc_disp", DISP_VALUE, 16'hFFAC);

        // Bouncy press, then a press while busy that must be dropped.
        lat_cycles = 30;
        launches   = 0;
        expect_op(8'sd3, 8'sd5, 1'b0);
        press_bouncy();
        check_val("busy_during_second_press", BUSY, 1);
        press_start();
        wait_sb_empty();
        cycles(20);
        check_val("bouncy_launches", launches, 1);
        lat_cycles = 10;

        // Clear, then saturating accumulation of 127*127.
        press_clr();
        MODE = 2'b10; #1;
        check_val("clr_acc", DISP_VALUE, 0);
        check_val("clr_sat", SAT, 0);
        for (int k = 0; k < 3; k++) begin
            expect_op(8'sd127, 8'sd127, 1'b0);
            press_start();
            wait_sb_empty();
        end
        check_val("sat_after_three", SAT, 1);
        press_clr();
        MODE = 2'b10; #1;
        check_val("clr2_acc", DISP_VALUE, 0);
        check_val("clr2_sat", SAT, 0);

        // Timeout: multiplier never answers.
        no_end = 1'b1;
        expect_op(8'sd5, 8'sd5, 1'b1);
        press_start();
        check_val("tmo_err_mid", ERR_TIMEOUT, 0);
        wait_sb_empty();
        check_val("tmo_busy_len_ok", (last_busy_len >= TMO && last_busy_len <= TMO + 2), 1);
        no_end = 1'b0;

        // Next press clears the timeout flag; then the mode sweep.
        expect_op(-8'sd128, -8'sd128, 1'b0);
        press_start();
        wait_sb_empty();
        MODE = 2'b01; #1;
        check_val("mode01", {DISP_SPLIT, DISP_VALUE}, {1'b0, 16'h4000});
        MODE = 2'b11;
        SW_A = 8'h05;
        SW_B = 8'hFD;
        #1;
        check_val("mode11", {DISP_SPLIT, DISP_VALUE}, {1'b1, 16'h8080});
        MODE = 2'b00; #1;
        check_val("mode00", {DISP_SPLIT, DISP_VALUE}, {1'b1, 16'h05FD});
        MODE = 2'b10; #1;
        check_val("mode10", {DISP_SPLIT, DISP_VALUE}, {1'b0, 16'h4000});

        // Reset during WAIT, then a late END_MULT from the model.
        SW_A = 8'sd3;
        SW_B = 8'sd3;
        MODE = 2'b10;
        seen = 1'b0;
        BTN_START = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge CLOCK);
            if (MULT_START) seen = 1'b1;
        end
        check_val("rst_test_launch_seen", seen, 1);
        repeat (3) @(negedge CLOCK);
        ends_before = end_count;
        #1;
        RESET     = 1'b0;
        BTN_START = 1'b1;
        #1;
        check_val("abort_start_busy", {MULT_START, BUSY}, 0);
        check_val("abort_ops", {A_OP, B_OP}, 0);
        check_val("abort_disp", {DISP_SPLIT, DISP_VALUE}, 0);
        check_val("abort_flags", {RESULT_VALID, SAT, ERR_TIMEOUT}, 0);
        cycles(2);
        RESET    = 1'b1;
        launches = 0;
        cycles(30);
        check_val("late_end_fired", (end_count > ends_before), 1);
        check_val("post_rst_launches", launches, 0);
        check_val("post_rst_rv", RESULT_VALID, 0);
        MODE = 2'b01; #1;
        check_val("post_rst_product", DISP_VALUE, 0);
        check_val("sb_left_over", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mult_console_ctrl
`default_nettype wire
